// File: rtl/mdr_lsu_pkg.sv
// Shared encodings and helpers for the memory data register / load-store unit.
// State codes stay plain localparams so legacy code comparing against them still works.
package mdr_lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RD_WAIT = 2'd1;
   localparam logic [1:0] ST_WR_WAIT = 2'd2;

   // Encoding 2'b11 behaves exactly like a word access.
   function automatic logic [1:0] norm_size(input logic [1:0] size);
      return (size == 2'b11) ? SZ_WORD : size;
   endfunction

   // Byte enables within one 32-bit lane group; the caller shifts to the selected group.
   function automatic logic [3:0] be_mask(input logic [1:0] size, input logic [1:0] addr);
      logic [3:0] m;
      case (norm_size(size))
         SZ_BYTE: m = 4'b0001;
         SZ_HALF: m = 4'b0011;
         default: m = 4'b1111;
      endcase
      return m << addr;
   endfunction

endpackage

// File: rtl/mdr_lane_align.sv
// Combinational lane logic: load extraction/extension and store replication/byte enables.
// Load and store sides have separate size/address inputs so each can use its own source.
module mdr_lane_align
   import mdr_lsu_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned AW     = $clog2(DATA_W/8)
) (
   input  logic [1:0]          ld_size_i,
   input  logic [AW-1:0]       ld_addr_i,
   input  logic                ld_unsigned_i,
   input  logic [DATA_W-1:0]   ld_raw_i,
   output logic [DATA_W-1:0]   ld_data_o,
   input  logic [1:0]          st_size_i,
   input  logic [AW-1:0]       st_addr_i,
   input  logic [DATA_W-1:0]   st_src_i,
   output logic [DATA_W-1:0]   st_data_o,
   output logic [DATA_W/8-1:0] st_be_o,
   output logic                st_aligned_o
);

   localparam int unsigned NB = DATA_W/8;

   logic [31:0]   ld_word;
   logic [AW-1:0] st_grp;

   always_comb begin
      ld_word = 32'(ld_raw_i >> {ld_addr_i, 3'b000});
      case (norm_size(ld_size_i))
         SZ_BYTE: ld_data_o = ld_unsigned_i ? DATA_W'(ld_word[7:0])  : DATA_W'($signed(ld_word[7:0]));
         SZ_HALF: ld_data_o = ld_unsigned_i ? DATA_W'(ld_word[15:0]) : DATA_W'($signed(ld_word[15:0]));
         default: ld_data_o = ld_unsigned_i ? DATA_W'(ld_word)       : DATA_W'($signed(ld_word));
      endcase
   end

   always_comb begin
      st_grp = st_addr_i & ~AW'(3);
      st_be_o = NB'(be_mask(st_size_i, st_addr_i[1:0])) << st_grp;
      case (norm_size(st_size_i))
         SZ_BYTE: begin
            st_data_o    = {(DATA_W/8){st_src_i[7:0]}};
            st_aligned_o = 1'b1;
         end
         SZ_HALF: begin
            st_data_o    = {(DATA_W/16){st_src_i[15:0]}};
            st_aligned_o = ~st_addr_i[0];
         end
         default: begin
            st_data_o    = {(DATA_W/32){st_src_i[31:0]}};
            st_aligned_o = (st_addr_i[1:0] == 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/mdr_lsu.sv
// Memory data register with a handshaked load/store port, alignment check and request timeout.
// Holds the FSM, wait counter, MDR and all registered memory-side outputs.
module mdr_lsu
   import mdr_lsu_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                         clk,
   input  logic                         clr,
   input  logic                         MDRin,
   input  logic                         Read,
   input  logic                         Write,
   input  logic [1:0]                   size,
   input  logic                         lsu_unsigned,
   input  logic [$clog2(DATA_W/8)-1:0]  addr_lo,
   input  logic [DATA_W-1:0]            BusMuxOut,
   input  logic [DATA_W-1:0]            Mdatain,
   input  logic                         mem_ready,
   output logic                         mem_rd,
   output logic                         mem_wr,
   output logic [DATA_W-1:0]            mem_wdata,
   output logic [DATA_W/8-1:0]          mem_be,
   output logic [DATA_W-1:0]            MDR_q,
   output logic [DATA_W-1:0]            BusMuxIn_MDR,
   output logic                         busy,
   output logic                         done,
   output logic                         misalign,
   output logic                         timeout
);

   localparam int unsigned AW = $clog2(DATA_W/8);
   localparam int unsigned NB = DATA_W/8;
   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic              rd_q, rd_d, wr_q, wr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [NB-1:0]     be_q, be_d;
   logic              done_q, done_d, mis_q, mis_d, to_q, to_d;
   logic [1:0]        rsize_q, rsize_d;
   logic [AW-1:0]     raddr_q, raddr_d;
   logic              runs_q, runs_d;

   logic [DATA_W-1:0] ld_data, st_data;
   logic [NB-1:0]     st_be;
   logic              st_aligned;
   logic              wait_expired;

   // Load attributes are latched at start so the MAR may move during the wait.
   mdr_lane_align #(.DATA_W(DATA_W), .AW(AW)) u_align (
      .ld_size_i     (rsize_q),
      .ld_addr_i     (raddr_q),
      .ld_unsigned_i (runs_q),
      .ld_raw_i      (Mdatain),
      .ld_data_o     (ld_data),
      .st_size_i     (size),
      .st_addr_i     (addr_lo),
      .st_src_i      (mdr_q),
      .st_data_o     (st_data),
      .st_be_o       (st_be),
      .st_aligned_o  (st_aligned)
   );

   assign wait_expired = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mdr_d   = mdr_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rsize_d = rsize_q;
      raddr_d = raddr_q;
      runs_d  = runs_q;
      done_d  = 1'b0;
      mis_d   = 1'b0;
      to_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (Read) begin
               if (st_aligned) begin
                  state_d = ST_RD_WAIT;
                  rd_d    = 1'b1;
                  rsize_d = size;
                  raddr_d = addr_lo;
                  runs_d  = lsu_unsigned;
               end else begin
                  mis_d = 1'b1;
               end
            end else if (Write) begin
               if (st_aligned) begin
                  state_d = ST_WR_WAIT;
                  wr_d    = 1'b1;
                  wdata_d = st_data;
                  be_d    = st_be;
               end else begin
                  mis_d = 1'b1;
               end
            end else if (MDRin) begin
               mdr_d = BusMuxOut;
            end
         end
         ST_RD_WAIT: begin
            if (mem_ready) begin
               mdr_d   = ld_data;
               rd_d    = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (wait_expired) begin
               rd_d    = 1'b0;
               to_d    = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_WR_WAIT: begin
            if (mem_ready || wait_expired) begin
               wr_d    = 1'b0;
               wdata_d = '0;
               be_d    = '0;
               done_d  = mem_ready;
               to_d    = ~mem_ready;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            wdata_d = '0;
            be_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         mdr_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         be_q    <= '0;
         done_q  <= 1'b0;
         mis_q   <= 1'b0;
         to_q    <= 1'b0;
         rsize_q <= '0;
         raddr_q <= '0;
         runs_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mdr_q   <= mdr_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         done_q  <= done_d;
         mis_q   <= mis_d;
         to_q    <= to_d;
         rsize_q <= rsize_d;
         raddr_q <= raddr_d;
         runs_q  <= runs_d;
      end
   end

   assign mem_rd       = rd_q;
   assign mem_wr       = wr_q;
   assign mem_wdata    = wdata_q;
   assign mem_be       = be_q;
   assign MDR_q        = mdr_q;
   assign BusMuxIn_MDR = mdr_q;
   assign busy         = (state_q != ST_IDLE);
   assign done         = done_q;
   assign misalign     = mis_q;
   assign timeout      = to_q;

endmodule

// File: tb/tb_mdr_lsu.sv
// Directed plus randomized checks of mdr_lsu (DATA_W=32, TIMEOUT=16) against an arithmetic reference.
module tb_mdr_lsu;

   localparam int unsigned DW = 32;
   localparam int unsigned TO = 16;

   logic          clk = 1'b0;
   logic          clr = 1'b1;
   logic          MDRin = 1'b0, Read = 1'b0, Write = 1'b0;
   logic [1:0]    size = 2'b00;
   logic          lsu_unsigned = 1'b0;
   logic [1:0]    addr_lo = 2'b00;
   logic [31:0]   BusMuxOut = '0, Mdatain = '0;
   logic          mem_ready = 1'b0;
   logic          mem_rd, mem_wr, busy, done, misalign, timeout;
   logic [31:0]   mem_wdata, MDR_q, BusMuxIn_MDR;
   logic [3:0]    mem_be;

   int unsigned   vectors = 0;
   int unsigned   errors  = 0;
   logic [31:0]   exp_mdr = '0;

   always #5 clk = ~clk;

   mdr_lsu #(.DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .clr(clr), .MDRin(MDRin), .Read(Read), .Write(Write),
      .size(size), .lsu_unsigned(lsu_unsigned), .addr_lo(addr_lo),
      .BusMuxOut(BusMuxOut), .Mdatain(Mdatain), .mem_ready(mem_ready),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .MDR_q(MDR_q), .BusMuxIn_MDR(BusMuxIn_MDR), .busy(busy), .done(done),
      .misalign(misalign), .timeout(timeout)
   );

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [1:0] a,
                                            input logic uns, input logic [31:0] d);
      int unsigned     n    = nbytes(sz);
      longint unsigned mask = (64'd1 << (8 * n)) - 1;
      longint unsigned v    = (longint'(d) >> (8 * int'(a))) & mask;
      if (!uns && (((v >> (8 * n - 1)) & 1) == 1)) v = v | ~mask;
      return v[31:0];
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
      int unsigned     n    = nbytes(sz);
      longint unsigned mask = (64'd1 << (8 * n)) - 1;
      longint unsigned r    = 0;
      for (int i = 0; i < 4 / int'(n); i++) r = r | ((longint'(d) & mask) << (8 * n * i));
      return r[31:0];
   endfunction

   function automatic logic [31:0] ref_be(input logic [1:0] sz, input logic [1:0] a);
      return ((32'd1 << nbytes(sz)) - 1) << a;
   endfunction

   function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] a);
      return (int'(a) % nbytes(sz)) == 0;
   endfunction

   task automatic do_read(input logic [1:0] sz, input logic [1:0] a, input logic uns,
                          input logic [31:0] d, input int unsigned dly);
      Read = 1'b1; size = sz; addr_lo = a; lsu_unsigned = uns;
      tick;
      Read = 1'b0;
      if (!is_aligned(sz, a)) begin
         chk("rd_misalign_pulse", 32'(misalign), 1);
         chk("rd_misalign_no_req", 32'(mem_rd), 0);
         chk("rd_misalign_mdr", MDR_q, exp_mdr);
         tick;
         chk("rd_misalign_once", 32'(misalign), 0);
         chk("rd_misalign_still_no_req", 32'(mem_rd), 0);
         return;
      end
      chk("rd_req", 32'(mem_rd), 1);
      chk("rd_busy", 32'(busy), 1);
      for (int i = 0; i < int'(dly); i++) begin
         Mdatain = $urandom;
         tick;
         chk("rd_wait_no_done", 32'(done), 0);
         chk("rd_wait_req", 32'(mem_rd), 1);
         chk("rd_wait_mdr", MDR_q, exp_mdr);
      end
      Mdatain = d; mem_ready = 1'b1;
      tick;
      mem_ready = 1'b0; Mdatain = $urandom;
      exp_mdr = ref_load(sz, a, uns, d);
      chk("rd_done", 32'(done), 1);
      chk("rd_data", MDR_q, exp_mdr);
      chk("rd_bus_mux", BusMuxIn_MDR, exp_mdr);
      chk("rd_req_drop", 32'(mem_rd), 0);
      tick;
      chk("rd_done_once", 32'(done), 0);
   endtask

   task automatic do_write(input logic [1:0] sz, input logic [1:0] a,
                           input logic [31:0] val, input int unsigned dly);
      logic [31:0] wd, be;
      MDRin = 1'b1; BusMuxOut = val;
      tick;
      MDRin = 1'b0;
      exp_mdr = val;
      chk("wr_mdrin", MDR_q, exp_mdr);
      Write = 1'b1; size = sz; addr_lo = a;
      tick;
      Write = 1'b0;
      if (!is_aligned(sz, a)) begin
         chk("wr_misalign_pulse", 32'(misalign), 1);
         chk("wr_misalign_no_req", 32'(mem_wr), 0);
         chk("wr_misalign_be", 32'(mem_be), 0);
         tick;
         chk("wr_misalign_once", 32'(misalign), 0);
         return;
      end
      wd = ref_wdata(sz, val);
      be = ref_be(sz, a);
      chk("wr_req", 32'(mem_wr), 1);
      chk("wr_wdata", mem_wdata, wd);
      chk("wr_be", 32'(mem_be), be);
      for (int i = 0; i < int'(dly); i++) begin
         MDRin = 1'b1; BusMuxOut = ~val;
         size = 2'($urandom); addr_lo = 2'($urandom);
         tick;
         chk("wr_hold_req", 32'(mem_wr), 1);
         chk("wr_hold_wdata", mem_wdata, wd);
         chk("wr_hold_be", 32'(mem_be), be);
         chk("wr_hold_no_done", 32'(done), 0);
      end
      MDRin = 1'b0; mem_ready = 1'b1;
      tick;
      mem_ready = 1'b0;
      chk("wr_done", 32'(done), 1);
      chk("wr_req_drop", 32'(mem_wr), 0);
      chk("wr_wdata_idle", mem_wdata, 0);
      chk("wr_be_idle", 32'(mem_be), 0);
      chk("wr_mdr_kept", MDR_q, exp_mdr);
      tick;
      chk("wr_done_once", 32'(done), 0);
   endtask

   initial begin
      // Reset with MDRin also asserted: reset wins.
      clr = 1'b1; MDRin = 1'b1; BusMuxOut = 32'h12345678;
      tick;
      chk("rst_mdr", MDR_q, 0);
      chk("rst_rd", 32'(mem_rd), 0);
      chk("rst_wr", 32'(mem_wr), 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_be", 32'(mem_be), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_pulses", {29'd0, done, misalign, timeout}, 0);
      clr = 1'b0;
      tick;
      MDRin = 1'b0;
      exp_mdr = 32'h12345678;
      chk("mdrin_load", MDR_q, exp_mdr);
      chk("mdrin_bus_mux", BusMuxIn_MDR, exp_mdr);

      // Byte loads from lane 2, signed then unsigned, the second with a 3-cycle wait.
      do_read(2'd0, 2'd2, 1'b0, 32'hDEADBEEF, 0);
      chk("ld_byte_signed", MDR_q, 32'hFFFFFFAD);
      do_read(2'd0, 2'd2, 1'b1, 32'hDEADBEEF, 3);
      chk("ld_byte_unsigned", MDR_q, 32'h000000AD);

      do_write(2'd1, 2'd2, 32'h0000BEEF, 3);
      chk("st_half_value", mem_wdata, 0);

      // Misaligned word read keeps the previous MDR.
      do_read(2'd2, 2'd1, 1'b0, 32'hCAFEF00D, 0);
      chk("misalign_mdr_kept", MDR_q, 32'h0000BEEF);

      for (int i = 0; i < 24; i++)
         do_read(2'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom_range(0, 4));
      for (int i = 0; i < 16; i++)
         do_write(2'($urandom), 2'($urandom), $urandom, $urandom_range(0, 4));

      // Timeout: mem_ready never arrives.
      Read = 1'b1; size = 2'd2; addr_lo = 2'd0;
      tick;
      Read = 1'b0;
      chk("to_req", 32'(mem_rd), 1);
      for (int i = 1; i < int'(TO); i++) begin
         tick;
         chk("to_early", 32'(timeout), 0);
         chk("to_req_held", 32'(mem_rd), 1);
      end
      tick;
      chk("to_pulse", 32'(timeout), 1);
      chk("to_req_drop", 32'(mem_rd), 0);
      chk("to_mdr_kept", MDR_q, exp_mdr);
      chk("to_idle", 32'(busy), 0);
      tick;
      chk("to_once", 32'(timeout), 0);

      // Simultaneous strobes: only the read starts.
      Read = 1'b1; Write = 1'b1; MDRin = 1'b1; BusMuxOut = 32'hA5A55A5A;
      size = 2'd3; addr_lo = 2'd0; lsu_unsigned = 1'b0;
      tick;
      Read = 1'b0; Write = 1'b0; MDRin = 1'b0;
      chk("prio_rd", 32'(mem_rd), 1);
      chk("prio_no_wr", 32'(mem_wr), 0);
      chk("prio_mdr", MDR_q, exp_mdr);
      Mdatain = 32'h89ABCDEF; mem_ready = 1'b1;
      tick;
      mem_ready = 1'b0;
      exp_mdr = 32'h89ABCDEF;
      chk("prio_rd_data", MDR_q, exp_mdr);
      chk("prio_done", 32'(done), 1);

      // Reset mid-read, then a stale mem_ready.
      Read = 1'b1; size = 2'd2; addr_lo = 2'd0;
      tick;
      Read = 1'b0;
      chk("clr_pre_req", 32'(mem_rd), 1);
      clr = 1'b1;
      tick;
      clr = 1'b0;
      exp_mdr = '0;
      chk("clr_req_drop", 32'(mem_rd), 0);
      chk("clr_idle", 32'(busy), 0);
      chk("clr_mdr", MDR_q, exp_mdr);
      Mdatain = 32'h13572468; mem_ready = 1'b1;
      tick;
      mem_ready = 1'b0;
      chk("clr_stale_no_done", 32'(done), 0);
      chk("clr_stale_mdr", MDR_q, exp_mdr);
      chk("clr_stale_no_req", 32'(mem_rd), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/mdr_lsu.md
# mdr_lsu

Parametrised memory data register with a handshaked memory port. It replaces the plain MDR as the CPU datapath's memory-side register. It loads from the internal bus or from memory, and performs byte, halfword and word loads and stores with lane selection, sign/zero extension, misalignment detection and a request timeout. It sits between the bus multiplexer and the memory subsystem, alongside the MAR, which supplies the low address bits.

## Interface
Parameters:
- DATA_W, 32, datapath and memory width; a multiple of 32.
- TIMEOUT, 16, maximum wait cycles for mem_ready; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- MDRin  in  1  load the full-width BusMuxOut into the MDR.
- Read  in  1  start a memory load.
- Write  in  1  start a memory store of MDR_q.
- size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- lsu_unsigned  in  1  1 means zero-extend loads; 0 means sign-extend.
- addr_lo  in  log2(DATA_W/8)  low address bits from the MAR.
- BusMuxOut  in  DATA_W  internal bus value.
- Mdatain  in  DATA_W  memory read data; valid when mem_ready is high.
- mem_ready  in  1  memory completes the current request.
- mem_rd  out  1  registered read request.
- mem_wr  out  1  registered write request.
- mem_wdata  out  DATA_W  store data, lane-replicated.
- mem_be  out  DATA_W/8  byte enables, one per lane.
- MDR_q  out  DATA_W  register contents.
- BusMuxIn_MDR  out  DATA_W  bus-mux source; combinationally equal to MDR_q.
- busy  out  1  high while in RD_WAIT or WR_WAIT.
- done  out  1  one-cycle pulse when a transfer completes.
- misalign  out  1  one-cycle pulse when a request is rejected as misaligned.
- timeout  out  1  one-cycle pulse when a request is aborted for timing out.

## Operation
- States: IDLE, RD_WAIT, WR_WAIT.
- Start priority in IDLE, evaluated at the clock edge: Read, then Write, then MDRin. Lower-priority strobes in the same cycle are ignored.
- Alignment rules:
  - A half access requires addr_lo[0]==0.
  - A word access requires a 32-bit-aligned addr_lo; for DATA_W>32, the lane group is selected by the upper addr_lo bits.
  - A misaligned request:
    - issues no memory request;
    - pulses misalign;
    - leaves MDR_q unchanged;
    - stays in IDLE.
- Aligned Read:
  - asserts mem_rd and enters RD_WAIT.
  - While mem_ready is sampled high in RD_WAIT, MDR_q captures the selected lane of Mdatain, extended to DATA_W per lsu_unsigned.
  - The block then deasserts mem_rd, pulses done and returns to IDLE.
- Aligned Write:
  - asserts mem_wr and enters WR_WAIT.
  - mem_wdata holds the low byte, half or word of MDR_q, replicated across all lanes.
  - mem_be holds a one-hot lane group at addr_lo.
  - mem_wdata and mem_be are captured at start and held stable until completion.
  - On mem_ready: deassert mem_wr, pulse done, return to IDLE.
- Timeout: a wait counter clears on entry to RD_WAIT or WR_WAIT and increments each wait cycle without mem_ready.
  - When the counter reaches TIMEOUT-1 with mem_ready still low:
    - drop the request;
    - pulse timeout;
    - leave MDR_q unchanged;
    - return to IDLE.
  - mem_ready in that same cycle wins over the timeout.
- Strobe handling outside IDLE: MDRin, Read and Write are ignored while busy.
- mem_ready sampled while in IDLE is ignored.
- Outside a store, mem_wdata is 0 and mem_be is all zeros.

## Timing
- Reset: when clr is sampled high, all of the following are 0 from the next cycle, regardless of state:
  - state returns to IDLE and the wait counter clears;
  - MDR_q, mem_rd, mem_wr, mem_wdata, mem_be, busy, done, misalign and timeout all read 0.
- A reset mid-transfer drops the request immediately; a mem_ready arriving later is ignored.
- MDRin load: MDR_q equals BusMuxOut from the cycle after the edge where MDRin is sampled.
- Request timing: mem_rd or mem_wr is high from the cycle after the start edge.
- Minimum latency:
  - with mem_ready high in the first request cycle, done and the new MDR_q appear 2 cycles after the start edge;
  - a new start is accepted in the done cycle.
- Misalign pulse: high in the cycle after the rejected start edge.
- Timeout pulse: occurs TIMEOUT cycles after the request first asserts.

## Structure
- Package mdr_lsu_pkg holds:
  - the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the state enumeration;
  - a function computing the byte-enable mask from size and addr_lo.
- Sub-module mdr_lane_align, purely combinational:
  - load path: lane extract plus sign/zero extension;
  - store path: lane replication plus byte-enable generation.
- The top level holds the FSM, the wait counter, the MDR register and the output registers.

## Test plan
All scenarios use DATA_W=32 and TIMEOUT=16.
- Reset and MDRin: assert clr, then MDRin with BusMuxOut=32'h12345678 → MDR_q=0 during reset, then 32'h12345678; BusMuxIn_MDR matches MDR_q.
- Load byte: Mdatain=32'hDEADBEEF, size=byte, addr_lo=2.
  - With lsu_unsigned=0 → MDR_q=32'hFFFFFFAD.
  - Repeated with lsu_unsigned=1 → 32'h000000AD.
  - mem_ready delayed 3 cycles → done exactly once.
- Store half: MDR_q=32'h0000BEEF, size=half, addr_lo=2 → mem_wdata=32'hBEEFBEEF and mem_be=4'b1100, held until mem_ready.
- Misaligned access: word Read at addr_lo=1 → mem_rd never asserts, misalign pulses once, MDR_q unchanged.
- Timeout: Read with mem_ready held low → timeout pulses 16 cycles after mem_rd rises, mem_rd drops, MDR_q unchanged.
- Busy and reset: Read+Write+MDRin asserted together → only the read occurs. clr during RD_WAIT, followed by mem_ready → IDLE state, MDR_q=0, no done.
